// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC post-processing stage.
//   ACC_W / OUT_W     : accumulator and output pixel widths
//   OUT_MAX / OUT_MIN : signed saturation bounds of an output pixel
//   state_t           : window-control FSM states
package mac_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int OUT_MAX = 32767;
  localparam int OUT_MIN = -32768;

  typedef enum logic [1:0] {
    ACCUM,
    CAPTURE,
    CLEAR
  } state_t;

endpackage

// File: rtl/mac_post_fifo.sv
// Small synchronous FIFO that holds finished output pixels for the layer writer.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wr_data   : write an entry (ignored only if full with no pop)
//   pop             : remove the head entry (ignored when empty)
//   rd_data, valid  : head entry and non-empty flag, both straight from flops
//   count           : number of stored entries
module mac_post_fifo #(
  parameter int W     = mac_pkg::OUT_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees the slot in the same cycle, so push-while-full is honoured
  // when it coincides with a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // NOTE: all sequential state is written with non-blocking (<=) assignments
  // so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset (only DEPTH words) so the head, and thus
      // out_data, reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = (count != '0);

endmodule

// File: rtl/mac_post.sv
// Downstream stage of the MAC: counts taps per output window, captures the
// finished sum, pulses a clear to the accumulator, then bias-adds, shifts,
// optionally ReLUs and saturates the result before buffering it.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   tap_valid/ready   : MAC accumulate strobe and this block's acceptance
//   mac_out           : signed accumulator value
//   num_taps          : taps per window, sampled on the first tap (0 means 1)
//   bias/shift/relu_en: post-processing controls, sampled in CAPTURE
//   acc_clear         : one-cycle clear request to the accumulator
//   out_data/valid/ready : buffered result stream to the layer writer
//   sat_flag          : sticky, set when any result saturated
module mac_post #(
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int OUT_W = mac_pkg::OUT_W,
  parameter int TAP_W = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tap_valid,
  output logic                    tap_ready,
  input  logic signed [ACC_W-1:0] mac_out,
  input  logic        [TAP_W-1:0] num_taps,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic                    acc_clear,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_flag
);

  import mac_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(OUT_MAX);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(OUT_MIN);

  state_t            state_q, state_d;
  logic [TAP_W-1:0]  count_q, count_d;
  logic [TAP_W-1:0]  win_len_q, win_len_d, win_len_cur;
  logic              run_q;

  logic                    s1_valid;
  logic signed [ACC_W:0]   s1_sum;
  logic        [4:0]       s1_shift;
  logic                    s1_relu;
  logic signed [ACC_W:0]   cap_sum;
  logic signed [ACC_W:0]   sh;
  logic        [OUT_W-1:0] res;
  logic                    sat_hit;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occ;

  // The stage-2 result register is the FIFO entry itself, so its valid is
  // already part of fifo_count. Only the registered view is used: a pop in
  // the current cycle does not free a slot until the next cycle.
  assign occ = {{CNT_W{1'b0}}, s1_valid} + {1'b0, fifo_count};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      win_len_q <= TAP_W'(1);
      run_q     <= 1'b0;   // holds tap_ready low until the first edge after reset
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      win_len_q <= win_len_d;
      run_q     <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    win_len_d   = win_len_q;
    tap_ready   = 1'b0;
    acc_clear   = 1'b0;
    // On the first tap the window length comes straight from num_taps.
    win_len_cur = (count_q != '0)      ? win_len_q :
                  (num_taps == '0)     ? TAP_W'(1) : num_taps;
    unique case (state_q)
      ACCUM: begin
        // A new window may only start if its result is sure to have a slot.
        tap_ready = run_q && !((count_q == '0) && (occ >= (CNT_W + 1)'(DEPTH)));
        if (tap_valid && tap_ready) begin
          win_len_d = win_len_cur;
          if (count_q == win_len_cur - TAP_W'(1)) begin
            state_d = CAPTURE;
            count_d = '0;
          end else begin
            count_d = count_q + TAP_W'(1);
          end
        end
      end
      CAPTURE: state_d = CLEAR;
      CLEAR: begin
        acc_clear = 1'b1;
        state_d   = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // ------------------------------------------------------------ stage 1
  // The accumulator is registered, so in CAPTURE mac_out already holds the
  // last tap. The add is one bit wider than the operands and cannot wrap.
  assign cap_sum = {mac_out[ACC_W-1], mac_out} + {bias[ACC_W-1], bias};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
    end else begin
      s1_valid <= (state_q == CAPTURE);
      if (state_q == CAPTURE) begin
        s1_sum   <= cap_sum;
        s1_shift <= shift;
        s1_relu  <= relu_en;
      end
    end
  end

  // ------------------------------------------------------------ stage 2
  // ReLU is applied before saturation, so a ReLU clamp never flags.
  always_comb begin
    sh = s1_sum >>> s1_shift;
    if (s1_relu && sh[ACC_W]) sh = '0;
    res     = sh[OUT_W-1:0];
    sat_hit = 1'b0;
    if (sh > SAT_HI) begin
      res     = SAT_HI[OUT_W-1:0];
      sat_hit = 1'b1;
    end else if (sh < SAT_LO) begin
      res     = SAT_LO[OUT_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sat_flag <= 1'b0;
    else if (s1_valid && sat_hit)  sat_flag <= 1'b1;
  end

  // ------------------------------------------------------- output buffer
  mac_post_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s1_valid),
    .wr_data (res),
    .pop     (out_valid && out_ready),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mac_post.sv
`timescale 1ns/1ps
module tb_mac_post;

  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int TAP_W = 8;
  localparam int DEPTH = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    tap_valid = 1'b0;
  logic                    tap_ready;
  logic signed [ACC_W-1:0] mac_out;
  logic        [TAP_W-1:0] num_taps = '0;
  logic signed [ACC_W-1:0] bias = '0;
  logic        [4:0]       shift = '0;
  logic                    relu_en = 1'b0;
  logic                    acc_clear;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    sat_flag;

  // Upstream MAC model: accumulates the tap value on each counted tap and
  // clears on acc_clear. Handshakes are sampled on the falling edge.
  logic signed [ACC_W-1:0] tap_val = '0;
  logic signed [ACC_W-1:0] acc;
  logic                    fire_s = 1'b0;
  logic                    clr_s  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [OUT_W-1:0] sb[$];

  always #5 clk = ~clk;

  mac_post #(.ACC_W(ACC_W), .OUT_W(OUT_W), .TAP_W(TAP_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .mac_out   (mac_out),
    .num_taps  (num_taps),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .acc_clear (acc_clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always @(negedge clk) begin
    fire_s = tap_valid && tap_ready;
    clr_s  = acc_clear;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clr_s) acc <= '0;
    else if (fire_s) acc <= acc + tap_val;
  end

  assign mac_out = acc;

  // Reference: bias add, arithmetic shift, ReLU, then saturation.
  function automatic logic signed [OUT_W-1:0] model(input logic signed [ACC_W-1:0] a,
                                                    input logic signed [ACC_W-1:0] b,
                                                    input logic [4:0] s, input logic r);
    longint v;
    v = (longint'(a) + longint'(b)) >>> s;
    if (r && v < 0) v = 0;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return OUT_W'(v);
  endfunction

  // Window of n taps summing to total: 100 per tap, remainder on the last.
  function automatic logic signed [ACC_W-1:0] tap_value(input int idx, input int n,
                                                        input logic signed [ACC_W-1:0] total);
    return (idx == n - 1) ? total - (n - 1) * 100 : 100;
  endfunction

  // Scoreboard consumer: every accepted output is checked in order.
  initial begin
    logic signed [OUT_W-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %0d, expected no output", out_data);
        end else begin
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            n_fail++;
            $display("FAIL sb_data: got %0d expected %0d", out_data, exp_v);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one full window and checks the CAPTURE and CLEAR cycles.
  // Returns at the falling edge of the CLEAR cycle (T+2).
  task automatic run_window(input string tag, input logic [TAP_W-1:0] cfg, input int n,
                            input logic signed [ACC_W-1:0] total,
                            input logic signed [ACC_W-1:0] b, input logic [4:0] s,
                            input logic r);
    int got = 0;
    int g   = 0;
    sb.push_back(model(total, b, s, r));
    @(posedge clk); #1;
    num_taps  = cfg; bias = b; shift = s; relu_en = r;
    tap_val   = tap_value(0, n, total);
    tap_valid = 1'b1;
    while (got < n && g < 200) begin
      @(negedge clk);
      if (tap_ready) got++;
      g++;
      @(posedge clk); #1;
      tap_val = tap_value(got, n, total);
      if (got == n) tap_valid = 1'b0;
    end
    tap_valid = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s_taps: accepted %0d expected %0d", tag, got, n);
    end
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b0 || acc_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_capture: tap_ready=%b acc_clear=%b expected 0 0", tag, tap_ready, acc_clear);
    end
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b0 || acc_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_clear: tap_ready=%b acc_clear=%b expected 0 1", tag, tap_ready, acc_clear);
    end
  endtask

  // Checks the result appearing at T+3 (buffer was empty, out_ready high).
  task automatic check_result(input string tag, input logic signed [OUT_W-1:0] exp_d,
                              input logic exp_sat);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || sat_flag !== exp_sat) begin
      n_fail++;
      $display("FAIL %s_result: valid=%b data=%0d sat=%b expected 1 %0d %b",
               tag, out_valid, out_data, sat_flag, exp_d, exp_sat);
    end
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while ((sb.size() != 0 || out_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results pending, out_valid=%b, expected 0 0", tag, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b0 || acc_clear !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 16'sd0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b clr=%b valid=%b data=%0d sat=%b expected all 0",
               tap_ready, acc_clear, out_valid, out_data, sat_flag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 0", tap_ready);
    end
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b expected 1", tap_ready);
    end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    out_ready = 1'b1;
    run_window("basic", 8'd9, 9, 1000, 24, 5'd3, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    check_result("basic", 16'sd128, 1'b0);
    wait_drain("basic");
  endtask

  task automatic test_relu();
    run_window("relu_on", 8'd1, 1, -5000, 0, 5'd0, 1'b1);
    check_result("relu_on", 16'sd0, 1'b0);
    run_window("relu_off", 8'd1, 1, -5000, 0, 5'd0, 1'b0);
    check_result("relu_off", -16'sd5000, 1'b0);
    run_window("relu_big", 8'd1, 1, -32'sh40000000, 0, 5'd0, 1'b1);
    check_result("relu_big", 16'sd0, 1'b0);
    wait_drain("relu");
  endtask

  task automatic test_num_taps_zero();
    run_window("zero_taps", 8'd0, 1, 777, 0, 5'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b1 || out_data !== 16'sd777 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_taps_after: ready=%b data=%0d valid=%b expected 1 777 1",
               tap_ready, out_data, out_valid);
    end
    wait_drain("zero_taps");
  endtask

  task automatic test_saturate();
    run_window("sat_pos", 8'd1, 1, 32'sh7FFF0000, 0, 5'd4, 1'b0);
    check_result("sat_pos", 16'sd32767, 1'b1);
    run_window("sat_neg", 8'd1, 1, -32'sh40000000, 0, 5'd0, 1'b0);
    check_result("sat_neg", -16'sd32768, 1'b1);
    run_window("sat_sticky", 8'd3, 3, 300, -50, 5'd1, 1'b0);
    check_result("sat_sticky", 16'sd125, 1'b1);
    wait_drain("sat");
  endtask

  task automatic test_backpressure();
    int n1 = 0;
    int n2 = 0;
    logic signed [ACC_W-1:0] v = 1000;
    @(posedge clk); #1;
    out_ready = 1'b0; num_taps = 8'd1; bias = 0; shift = 0; relu_en = 0;
    tap_val = v; tap_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tap_ready) begin n1++; sb.push_back(model(tap_val, 0, 5'd0, 1'b0)); end
      @(posedge clk); #1;
      v = v + 7; tap_val = v;
    end
    @(negedge clk);
    n_checks++;
    if (n1 != 2 || tap_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'sd1000) begin
      n_fail++;
      $display("FAIL bp_full: accepted=%0d ready=%b valid=%b data=%0d expected 2 0 1 1000",
               n1, tap_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tap_ready) begin n2++; sb.push_back(model(tap_val, 0, 5'd0, 1'b0)); end
      @(posedge clk); #1;
      v = v + 7; tap_val = v;
    end
    tap_valid = 1'b0;
    n_checks++;
    if (n2 < 9) begin
      n_fail++;
      $display("FAIL bp_resume: accepted %0d taps after release, expected at least 9", n2);
    end
    wait_drain("bp");
  endtask

  task automatic test_reset_mid();
    int got = 0;
    int g   = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_window("rm_buf", 8'd1, 1, 42, 0, 5'd0, 1'b0);
    check_result("rm_buf", 16'sd42, 1'b1);
    @(posedge clk); #1;
    num_taps = 8'd9; tap_val = 100; tap_valid = 1'b1;
    while (got < 4 && g < 100) begin
      @(negedge clk);
      if (tap_ready) got++;
      g++;
      @(posedge clk); #1;
    end
    tap_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++;
    if (got != 4 || out_valid !== 1'b0 || out_data !== 16'sd0 || tap_ready !== 1'b0 ||
        acc_clear !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_in_reset: taps=%0d valid=%b data=%0d ready=%b clr=%b sat=%b expected 4 0 0 0 0 0",
               got, out_valid, out_data, tap_ready, acc_clear, sat_flag);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tap_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_release: ready=%b valid=%b expected 0 0", tap_ready, out_valid);
    end
    run_window("rm_next", 8'd9, 9, 900, -4, 5'd2, 1'b0);
    check_result("rm_next", 16'sd224, 1'b0);
    wait_drain("rm");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_num_taps_zero();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
